conv_array: RTL and testbench
=============================

// Module: conv_array
// PURPOSE
//  N-lane 3x3 convolution engine, directly downstream of the MCU. Consumes the 3-row x N-lane pixel
//  columns the MCU presents on its o_DataConv and returns N 13-bit results to the MCU i_DataConv.
//  Each lane holds a sliding 3x3 window over the streamed columns and runs a 2-stage MAC pipeline
//  against a shared, software-loaded kernel.
// PARAMETERS
//  N            2   lanes; MCU memory count = N+2
//  BITS_IMAGEN  8   unsigned pixel width
//  BITS_DATA    13  signed result width
//  BITS_COEF    8   signed kernel coefficient width
//  SHIFT        7   arithmetic right shift applied to the accumulator (Q0.7 kernel)
// PORTS
//  clk           in   1                 clock
//  rst           in   1                 synchronous, active-high reset
//  i_sol         in   1                 start of line: restarts window fill
//  i_eol         in   1                 end of line: return to IDLE
//  i_valid       in   1                 column strobe for i_DataConv
//  i_DataConv    in   3*N*BITS_IMAGEN   lane k = bits [(3k+3)*BI-1:3k*BI]; row 0 in low byte
//  i_KernelLoad  in   1                 kernel load strobe
//  i_Kernel      in   9*BITS_COEF       coefficient (r,c) at index 3r+c; c=0 = oldest column
//  o_DataConv    out  N*BITS_DATA       lane k result at [(k+1)*BD-1:k*BD]
//  o_valid       out  1                 o_DataConv valid, 1-cycle pulse per result
//  o_busy        out  1                 state != IDLE
// BEHAVIOUR
//  Reset values: o_DataConv=0, o_valid=0, o_busy=0, state=IDLE, column count=0, kernel=0,
//   window=0, pipeline valid bits=0.
//  FSM: IDLE -(i_sol)-> FILL -(2nd accepted column)-> RUN -(i_eol)-> IDLE.
//  i_sol in any state: go to FILL, column count=0; an i_valid in the same cycle counts as column 1.
//  FILL: each i_valid shifts the column into the window; after 2 columns -> RUN with no output.
//  RUN: each i_valid shifts the window and launches a result.
//  i_valid in IDLE is ignored.
//  i_eol with i_valid in the same cycle: the column is processed (result emitted if in RUN), then IDLE.
//  Latency: i_valid sampled at edge k -> o_valid=1 with the result after edge k+2.
//   Stage 1 registers the 9 products per lane; stage 2 registers the adder tree, shift and clamp.
//  In-flight results always complete: i_sol, i_eol and kernel loads do not flush the pipeline.
//  rst does flush the pipeline: o_valid=0 after the reset edge.
//  Arithmetic: pixel zero-extended to 9b signed, multiplied by an 8b signed coefficient -> 17b.
//   Sum of 9 products -> 21b signed accumulator. Result = acc >>> SHIFT, reduced to BITS_DATA.
//  Kernel: i_KernelLoad is accepted only in IDLE; ignored when o_busy=1.
//   A new kernel applies to columns accepted after the load edge.
//  o_DataConv holds its last value while o_valid=0.
// CONFIGURATION
//  CONV_SATURATE_EN defined: shifted value clamped to [-2^(BD-1), 2^(BD-1)-1] = [-4096, 4095].
//  CONV_SATURATE_EN undefined: keep the low BITS_DATA bits of the shifted value (two's-complement wrap).
// STRUCTURE
//  conv_pkg: BITS_* defaults, ACC_W=21, KERNEL_TAPS=9, tap index function idx(r,c)=3r+c,
//   FSM state typedef {IDLE, FILL, RUN}.
//  Sub-module conv_lane: one 3x3 window, 9 multipliers and the 2-stage pipeline; instantiated N times.
//  conv_array itself holds the FSM, the kernel register and lane fan-out/concat.
// TESTING
//  1 Identity: kernel center(1,1)=127, others 0; load in IDLE; i_sol, then 3 columns of all pixels=100
//    -> single o_valid 2 cycles after 3rd column, each lane = 99.
//  2 Fill/stream: i_sol + 6 consecutive columns, lane0 rows = column index 1..6, kernel row1 = {1,1,1}
//    -> 4 results: (6,9,12,15)>>>7 = 0 each. With SHIFT=0: 6,9,12,15 on consecutive cycles.
//  3 Saturate, SHIFT=0: kernel all -128, pixels 255 -> acc=-293760.
//    With CONV_SATURATE_EN: -4096. Without: low 13b of -293760 = 1152.
//  4 Kernel load while busy: i_KernelLoad during RUN -> ignored, results unchanged.
//    After i_eol, the same load takes effect on the next line.
//  5 Line restart: i_sol asserted mid-RUN together with i_valid -> in-flight 2 results still emitted;
//    next result only after 2 further columns.
//  6 Reset mid-operation: rst in RUN with 2 results in flight -> no o_valid afterwards.
//    o_DataConv=0, o_busy=0, kernel=0 (a following line gives 0 results).

Source files
------------

// File: rtl/conv_pkg.sv
// Shared widths, tap indexing and FSM state type for the N-lane 3x3 convolution engine.
package conv_pkg;

  localparam int BITS_IMAGEN   = 8;
  localparam int BITS_DATA     = 13;
  localparam int BITS_COEF     = 8;
  localparam int SHIFT_DEFAULT = 7;
  localparam int ACC_W         = 21;
  localparam int KERNEL_TAPS   = 9;
  localparam int PROD_W        = BITS_IMAGEN + 1 + BITS_COEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Coefficient (r,c) sits at tap 3r+c; c=0 is the oldest column in the window.
  function automatic int idx(input int r, input int c);
    return 3 * r + c;
  endfunction

endpackage

// File: rtl/conv_array_if.sv
// MCU-facing bus of the convolution engine: column/kernel inputs and result outputs.
interface conv_array_if
  import conv_pkg::*;
#(
  parameter int N = 2
);

  logic                               i_sol;
  logic                               i_eol;
  logic                               i_valid;
  logic [3*N*BITS_IMAGEN-1:0]         i_DataConv;
  logic                               i_KernelLoad;
  logic [KERNEL_TAPS*BITS_COEF-1:0]   i_Kernel;
  logic [N*BITS_DATA-1:0]             o_DataConv;
  logic                               o_valid;
  logic                               o_busy;

  modport master (
    output i_sol, i_eol, i_valid, i_DataConv, i_KernelLoad, i_Kernel,
    input  o_DataConv, o_valid, o_busy
  );

  modport slave (
    input  i_sol, i_eol, i_valid, i_DataConv, i_KernelLoad, i_Kernel,
    output o_DataConv, o_valid, o_busy
  );

endinterface

// File: rtl/conv_lane.sv
// One lane: 3x3 sliding window, nine multipliers, product register and sum/shift/reduce register.
// Result reduction saturates when CONV_SATURATE_EN is defined, otherwise wraps.
module conv_lane
  import conv_pkg::*;
#(
  parameter int SHIFT = SHIFT_DEFAULT
)
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             shift_i,
  input  logic                             prod_en_i,
  input  logic                             res_en_i,
  input  logic [3*BITS_IMAGEN-1:0]         col_i,
  input  logic [KERNEL_TAPS*BITS_COEF-1:0] kernel_i,
  output logic [BITS_DATA-1:0]             res_o
);

  logic [BITS_IMAGEN-1:0]   win_q  [3][3];
  logic signed [PROD_W-1:0] prod_s [KERNEL_TAPS];
  logic signed [PROD_W-1:0] prod_q [KERNEL_TAPS];
  logic signed [ACC_W-1:0]  acc_s;
  logic signed [ACC_W-1:0]  shifted_s;
  logic [BITS_DATA-1:0]     res_d;
  logic [BITS_DATA-1:0]     res_q;

  // Window shift: column 2 receives the newest pixels, column 0 holds the oldest.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 3; c++) begin
        for (int r = 0; r < 3; r++) begin
          win_q[c][r] <= '0;
        end
      end
    end else if (shift_i) begin
      for (int r = 0; r < 3; r++) begin
        win_q[0][r] <= win_q[1][r];
        win_q[1][r] <= win_q[2][r];
        win_q[2][r] <= col_i[r*BITS_IMAGEN +: BITS_IMAGEN];
      end
    end
  end

  // Pixels are unsigned, so they are zero-extended before the signed multiply.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        prod_s[idx(r, c)] = PROD_W'(signed'({1'b0, win_q[c][r]}))
                          * PROD_W'(signed'(kernel_i[idx(r, c)*BITS_COEF +: BITS_COEF]));
      end
    end
  end

  // Stage 1: product register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < KERNEL_TAPS; t++) begin
        prod_q[t] <= '0;
      end
    end else if (prod_en_i) begin
      prod_q <= prod_s;
    end
  end

  // Adder tree, arithmetic shift and reduction to the result width.
  always_comb begin
    acc_s = '0;
    for (int t = 0; t < KERNEL_TAPS; t++) begin
      acc_s = acc_s + ACC_W'(prod_q[t]);
    end
    shifted_s = acc_s >>> SHIFT;
  end

`ifdef CONV_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (BITS_DATA - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (BITS_DATA - 1)));

  // Clamp to the signed result range.
  always_comb begin
    if (shifted_s > SAT_MAX) begin
      res_d = SAT_MAX[BITS_DATA-1:0];
    end else if (shifted_s < SAT_MIN) begin
      res_d = SAT_MIN[BITS_DATA-1:0];
    end else begin
      res_d = shifted_s[BITS_DATA-1:0];
    end
  end
`else
  logic [ACC_W-BITS_DATA-1:0] unused_hi_s;
  assign unused_hi_s = shifted_s[ACC_W-1:BITS_DATA];

  // Two's-complement wrap: keep the low result bits.
  always_comb begin
    res_d = shifted_s[BITS_DATA-1:0];
  end
`endif

  // Stage 2: result register, holds its value between results.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
    end else if (res_en_i) begin
      res_q <= res_d;
    end
  end

  assign res_o = res_q;

endmodule

// File: rtl/conv_array.sv
// N-lane 3x3 convolution engine: line FSM, shared kernel register and lane fan-out.
// Optional CONV_SATURATE_EN selects saturating result reduction in every lane.
module conv_array
  import conv_pkg::*;
#(
  parameter int N     = 2,
  parameter int SHIFT = SHIFT_DEFAULT
)
(
  input logic          clk,
  input logic          rst,
  conv_array_if.slave  bus
);

  state_e                           state_q, state_d;
  logic [1:0]                       cnt_q, cnt_d;
  logic                             accept_s;
  logic                             launch_s;
  logic                             v0_q, v1_q, v2_q;
  logic [KERNEL_TAPS*BITS_COEF-1:0] kernel_q;
  logic [N*BITS_DATA-1:0]           res_s;

  // FSM and column counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // i_sol overrides the current state; a column in the same cycle counts as the first.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_s = 1'b0;
    launch_s = 1'b0;
    if (bus.i_sol) begin
      state_d  = FILL;
      cnt_d    = bus.i_valid ? 2'd1 : 2'd0;
      accept_s = bus.i_valid;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        FILL: begin
          accept_s = bus.i_valid;
          if (bus.i_eol) begin
            state_d = IDLE;
          end else if (bus.i_valid && (cnt_q == 2'd1)) begin
            state_d = RUN;
          end else begin
            state_d = FILL;
          end
          if (bus.i_valid) begin
            cnt_d = (cnt_q == 2'd1) ? 2'd0 : cnt_q + 2'd1;
          end else begin
            cnt_d = cnt_q;
          end
        end
        RUN: begin
          accept_s = bus.i_valid;
          launch_s = bus.i_valid;
          if (bus.i_eol) begin
            state_d = IDLE;
          end else begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  // Kernel loads only while idle so a line never sees a mid-stream coefficient change.
  always_ff @(posedge clk) begin
    if (rst) begin
      kernel_q <= '0;
    end else if (bus.i_KernelLoad && (state_q == IDLE)) begin
      kernel_q <= bus.i_Kernel;
    end
  end

  // Result valid pipeline: window loaded, products registered, result registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q <= 1'b0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      v0_q <= launch_s;
      v1_q <= v0_q;
      v2_q <= v1_q;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_lane
    conv_lane #(.SHIFT(SHIFT)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .shift_i   (accept_s),
      .prod_en_i (v0_q),
      .res_en_i  (v1_q),
      .col_i     (bus.i_DataConv[3*k*BITS_IMAGEN +: 3*BITS_IMAGEN]),
      .kernel_i  (kernel_q),
      .res_o     (res_s[k*BITS_DATA +: BITS_DATA])
    );
  end

  assign bus.o_DataConv = res_s;
  assign bus.o_valid    = v2_q;
  assign bus.o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_conv_array.sv
// Bench for conv_array: one SHIFT=7 and one SHIFT=0 instance on shared stimulus, checked each cycle
// against a line/window model that computes 3x3 sums directly from the accepted columns.
module tb_conv_array;
  import conv_pkg::*;

  localparam int N  = 2;
  localparam int BD = BITS_DATA;
  localparam int BI = BITS_IMAGEN;
  localparam int BC = BITS_COEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sol = 1'b0, eol = 1'b0, vld = 1'b0, kl = 1'b0;
  logic [3*N*BI-1:0]          px   = '0;
  logic [KERNEL_TAPS*BC-1:0]  kern = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  conv_array_if #(.N(N)) bus7 ();
  conv_array_if #(.N(N)) bus0 ();

  assign bus7.i_sol = sol;        assign bus0.i_sol = sol;
  assign bus7.i_eol = eol;        assign bus0.i_eol = eol;
  assign bus7.i_valid = vld;      assign bus0.i_valid = vld;
  assign bus7.i_DataConv = px;    assign bus0.i_DataConv = px;
  assign bus7.i_KernelLoad = kl;  assign bus0.i_KernelLoad = kl;
  assign bus7.i_Kernel = kern;    assign bus0.i_Kernel = kern;

  conv_array #(.N(N), .SHIFT(7)) dut7 (.clk(clk), .rst(rst), .bus(bus7));
  conv_array #(.N(N), .SHIFT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  // ---------------- reference model ----------------
  typedef struct {
    longint           due;
    logic [N*BD-1:0]  r7;
    logic [N*BD-1:0]  r0;
  } res_t;

  int      hist [N][3][3];   // lane, column (0 = oldest), row
  int      kern_m [KERNEL_TAPS];
  bit      active = 1'b0;
  int      cnt = 0;
  longint  edge_no = 0;
  res_t    pend [$];
  logic [N*BD-1:0] hold7 = '0, hold0 = '0;
  bit      exp_valid = 1'b0;

  function automatic logic [BD-1:0] reduce(input longint acc, input int sh);
    longint s;
    s = acc >>> sh;
`ifdef CONV_SATURATE_EN
    if (s > 64'sd4095) s = 64'sd4095;
    else if (s < -64'sd4096) s = -64'sd4096;
`endif
    return BD'(s);
  endfunction

  task automatic model_edge();
    bit   busy_before, launch;
    res_t r;
    longint acc;
    if (rst) begin
      active = 1'b0; cnt = 0; exp_valid = 1'b0; hold7 = '0; hold0 = '0;
      pend.delete();
      for (int k = 0; k < N; k++)
        for (int c = 0; c < 3; c++)
          for (int q = 0; q < 3; q++) hist[k][c][q] = 0;
      for (int t = 0; t < KERNEL_TAPS; t++) kern_m[t] = 0;
      edge_no++;
      return;
    end
    busy_before = active;
    launch = 1'b0;
    if (sol) begin active = 1'b1; cnt = 0; end
    if (active && vld) begin
      for (int k = 0; k < N; k++) begin
        for (int q = 0; q < 3; q++) begin
          hist[k][0][q] = hist[k][1][q];
          hist[k][1][q] = hist[k][2][q];
          hist[k][2][q] = int'(px[(3*k+q)*BI +: BI]);
        end
      end
      if (cnt < 3) cnt++;
      launch = (cnt >= 3);
    end
    if (eol && !sol) active = 1'b0;
    if (launch) begin
      r.due = edge_no + 2;
      for (int k = 0; k < N; k++) begin
        acc = 0;
        for (int q = 0; q < 3; q++)
          for (int c = 0; c < 3; c++) acc += longint'(hist[k][c][q] * kern_m[3*q+c]);
        r.r7[k*BD +: BD] = reduce(acc, 7);
        r.r0[k*BD +: BD] = reduce(acc, 0);
      end
      pend.push_back(r);
    end
    if (kl && !busy_before)
      for (int t = 0; t < KERNEL_TAPS; t++) kern_m[t] = int'($signed(kern[t*BC +: BC]));
    exp_valid = 1'b0;
    if (pend.size() > 0 && pend[0].due == edge_no) begin
      exp_valid = 1'b1;
      hold7 = pend[0].r7;
      hold0 = pend[0].r0;
      void'(pend.pop_front());
    end
    edge_no++;
  endtask

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_no, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("valid7", 64'(bus7.o_valid), 64'(exp_valid));
    check_eq("valid0", 64'(bus0.o_valid), 64'(exp_valid));
    check_eq("data7", 64'(bus7.o_DataConv), 64'(hold7));
    check_eq("data0", 64'(bus0.o_DataConv), 64'(hold0));
    check_eq("busy7", 64'(bus7.o_busy), 64'(active));
    check_eq("busy0", 64'(bus0.o_busy), 64'(active));
  endtask

  function automatic logic [3*N*BI-1:0] all_pix(input logic [BI-1:0] p);
    logic [3*N*BI-1:0] v;
    for (int i = 0; i < 3*N; i++) v[i*BI +: BI] = p;
    return v;
  endfunction

  function automatic logic [3*N*BI-1:0] rand_pix();
    logic [3*N*BI-1:0] v;
    for (int i = 0; i < 3*N; i++) v[i*BI +: BI] = BI'($urandom);
    return v;
  endfunction

  function automatic logic [KERNEL_TAPS*BC-1:0] fill_kern(input logic [BC-1:0] c);
    logic [KERNEL_TAPS*BC-1:0] v;
    for (int t = 0; t < KERNEL_TAPS; t++) v[t*BC +: BC] = c;
    return v;
  endfunction

  function automatic logic [KERNEL_TAPS*BC-1:0] rand_kern();
    logic [KERNEL_TAPS*BC-1:0] v;
    int mode;
    mode = int'($urandom_range(0, 3));
    if (mode == 0) v = fill_kern(8'h80);
    else if (mode == 1) v = fill_kern(8'h7f);
    else for (int t = 0; t < KERNEL_TAPS; t++) v[t*BC +: BC] = BC'($urandom);
    return v;
  endfunction

`ifdef CONV_SATURATE_EN
  localparam logic [BD-1:0] ID0  = 13'd4095;
  localparam logic [BD-1:0] SAT0 = 13'h1000;
`else
  localparam logic [BD-1:0] ID0  = 13'd4508;
  localparam logic [BD-1:0] SAT0 = 13'd1152;
`endif
  localparam logic [BD-1:0] ID7  = 13'd99;
  localparam logic [BD-1:0] SAT7 = 13'd5897;

  initial begin
    // reset
    rst = 1'b1; step(); step();
    rst = 1'b0; step();

    // identity kernel, pixels 100
    kern = '0; kern[4*BC +: BC] = 8'd127; kl = 1'b1; step(); kl = 1'b0;
    sol = 1'b1; vld = 1'b1; px = all_pix(8'd100); step();
    sol = 1'b0; step(); step();
    vld = 1'b0; step(); step(); step(); step();
    check_eq("ident7", 64'(bus7.o_DataConv), 64'({ID7, ID7}));
    check_eq("ident0", 64'(bus0.o_DataConv), 64'({ID0, ID0}));

    // full-scale negative sum
    eol = 1'b1; step(); eol = 1'b0;
    kern = fill_kern(8'h80); kl = 1'b1; step(); kl = 1'b0;
    sol = 1'b1; vld = 1'b1; px = all_pix(8'd255); step();
    sol = 1'b0; step(); step();
    vld = 1'b0; step(); step(); step();
    check_eq("sat7", 64'(bus7.o_DataConv), 64'({SAT7, SAT7}));
    check_eq("sat0", 64'(bus0.o_DataConv), 64'({SAT0, SAT0}));

    // kernel load during RUN is ignored, then applies after eol
    sol = 1'b1; vld = 1'b1; px = rand_pix(); step(); sol = 1'b0;
    for (int i = 0; i < 4; i++) begin px = rand_pix(); step(); end
    kern = fill_kern(8'h7f); kl = 1'b1; px = rand_pix(); step();
    kl = 1'b0; px = rand_pix(); step();
    vld = 1'b0; eol = 1'b1; step(); eol = 1'b0;
    kl = 1'b1; step(); kl = 1'b0;
    sol = 1'b1; vld = 1'b1; px = rand_pix(); step(); sol = 1'b0;
    for (int i = 0; i < 4; i++) begin px = rand_pix(); step(); end

    // restart mid-RUN with a column, then reset with results in flight
    sol = 1'b1; px = rand_pix(); step(); sol = 1'b0;
    for (int i = 0; i < 4; i++) begin px = rand_pix(); step(); end
    vld = 1'b0; rst = 1'b1; step(); rst = 1'b0;
    step(); step(); step();
    sol = 1'b1; vld = 1'b1; px = rand_pix(); step(); sol = 1'b0;
    for (int i = 0; i < 4; i++) begin px = rand_pix(); step(); end
    vld = 1'b0; eol = 1'b1; step(); eol = 1'b0; step(); step();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      sol  = ($urandom_range(0, 19) == 0);
      eol  = !sol && ($urandom_range(0, 24) == 0);
      vld  = ($urandom_range(0, 9) < 7);
      kl   = ($urandom_range(0, 9) == 0);
      if (kl) kern = rand_kern();
      px   = ($urandom_range(0, 3) == 0) ? all_pix(8'd255) : rand_pix();
      rst  = ($urandom_range(0, 299) == 0);
      step();
    end
    sol = 1'b0; eol = 1'b0; vld = 1'b0; kl = 1'b0; rst = 1'b0;
    step(); step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
